// File: rtl/gelu_pkg.sv
// gelu_pkg: Q-format defaults, region encoding and saturation helper for the GELU unit
package gelu_pkg;

    localparam int GELU_DATA_WIDTH = 16;
    localparam int GELU_FRAC_BITS  = 10;
    localparam int GELU_ADDR_BITS  = 6;
    localparam int GELU_STEP_SHIFT = 7;
    localparam int GELU_LUT_MIN    = -4096;

    typedef enum logic [1:0] {
        REG_IN   = 2'd0,
        REG_LOW  = 2'd1,
        REG_HIGH = 2'd2
    } region_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

endpackage

// File: rtl/gelu_lut_ram.sv
// gelu_lut_ram: GELU sample table, one sync write port and two registered read ports (idx, idx+1)
module gelu_lut_ram
    import gelu_pkg::*;
#(
    parameter int DATA_WIDTH = GELU_DATA_WIDTH,
    parameter int ADDR_BITS  = GELU_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr_a,
    input  logic [ADDR_BITS-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
    logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;

    // Read registers hold while the pipeline is stalled.
    always_comb begin
        rd_a_d = re ? mem[raddr_a] : rd_a_q;
        rd_b_d = re ? mem[raddr_b] : rd_b_q;
    end

    // Table is never reset; a write lands after same-edge reads, so those see the old value.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_a_q <= rd_a_d;
        rd_b_q <= rd_b_d;
    end

    assign rdata_a = rd_a_q;
    assign rdata_b = rd_b_q;

endmodule

// File: rtl/gelu_lut_interp.sv
// gelu_lut_interp: 3-stage streaming GELU via programmable LUT with linear interpolation.
// Build option GELU_INTERP_ROUND_EN: round the interpolation term to nearest (half up) instead of floor.
module gelu_lut_interp
    import gelu_pkg::*;
#(
    parameter int DATA_WIDTH = GELU_DATA_WIDTH,
    parameter int FRAC_BITS  = GELU_FRAC_BITS,
    parameter int ADDR_BITS  = GELU_ADDR_BITS,
    parameter int STEP_SHIFT = GELU_STEP_SHIFT,
    parameter int LUT_MIN    = GELU_LUT_MIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_oor,
    input  logic                  cfg_we,
    input  logic [ADDR_BITS-1:0]  cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data
);

    localparam int N  = 1 << ADDR_BITS;
    localparam int PW = DATA_WIDTH + STEP_SHIFT + 2;
    localparam logic signed [DATA_WIDTH:0] LUT_MIN_W = (DATA_WIDTH + 1)'(LUT_MIN);
    localparam logic signed [DATA_WIDTH:0] SPAN      = (DATA_WIDTH + 1)'((N - 1) << STEP_SHIFT);
`ifdef GELU_INTERP_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (STEP_SHIFT - 1);
`endif

    if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_q
        $error("FRAC_BITS must be below DATA_WIDTH");
    end

    logic                    en;
    logic signed [DATA_WIDTH:0] off;
    region_e                 region_n;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_x_q, s1_x_d;
    region_e                 s1_reg_q, s1_reg_d;
    logic [ADDR_BITS-1:0]    s1_idx_q, s1_idx_d;
    logic [ADDR_BITS-1:0]    s1_idx_nx;
    logic [STEP_SHIFT-1:0]   s1_frac_q, s1_frac_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]   s2_x_q, s2_x_d;
    region_e                 s2_reg_q, s2_reg_d;
    logic [STEP_SHIFT-1:0]   s2_frac_q, s2_frac_d;
    logic [DATA_WIDTH-1:0]   lut_lo, lut_hi;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]    prod, term, sum;
    logic [DATA_WIDTH-1:0]   y;
    logic                    ld;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_oor_q, out_oor_d;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // Stage 1: offset from table origin, classify range, split into index and fraction.
    always_comb begin
        off        = (DATA_WIDTH + 1)'($signed(in_data)) - LUT_MIN_W;
        region_n   = (off < 0) ? REG_LOW : ((off >= SPAN) ? REG_HIGH : REG_IN);
        s1_valid_d = en ? in_valid : s1_valid_q;
        s1_x_d     = en ? in_data : s1_x_q;
        s1_reg_d   = en ? region_n : s1_reg_q;
        s1_idx_d   = en ? ((region_n == REG_IN) ? off[STEP_SHIFT +: ADDR_BITS] : '0) : s1_idx_q;
        s1_frac_d  = en ? off[STEP_SHIFT-1:0] : s1_frac_q;
        s1_idx_nx  = s1_idx_q + ADDR_BITS'(1);
    end

    gelu_lut_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (cfg_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .re      (en),
        .raddr_a (s1_idx_q),
        .raddr_b (s1_idx_nx),
        .rdata_a (lut_lo),
        .rdata_b (lut_hi)
    );

    // Stage 2: carry sample metadata alongside the registered table reads.
    always_comb begin
        s2_valid_d = en ? s1_valid_q : s2_valid_q;
        s2_x_d     = en ? s1_x_q : s2_x_q;
        s2_reg_d   = en ? s1_reg_q : s2_reg_q;
        s2_frac_d  = en ? s1_frac_q : s2_frac_q;
    end

    // Stage 3: interpolate between neighbours, saturate, or apply the out-of-range policy.
    always_comb begin
        diff = (DATA_WIDTH + 1)'($signed(lut_hi)) - (DATA_WIDTH + 1)'($signed(lut_lo));
        prod = PW'(diff) * PW'($signed({1'b0, s2_frac_q}));
`ifdef GELU_INTERP_ROUND_EN
        term = (prod + RND) >>> STEP_SHIFT;
`else
        term = prod >>> STEP_SHIFT;
`endif
        sum         = PW'($signed(lut_lo)) + term;
        y           = (s2_reg_q == REG_IN) ? DATA_WIDTH'(sat_s(64'(sum), DATA_WIDTH))
                    : ((s2_reg_q == REG_LOW) ? '0 : s2_x_q);
        ld          = en & s2_valid_q;
        out_valid_d = en ? s2_valid_q : out_valid_q;
        out_data_d  = ld ? y : out_data_q;
        out_oor_d   = ld ? (s2_reg_q != REG_IN) : out_oor_q;
    end

    // Pipeline registers; reset empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_reg_q    <= REG_IN;
            s1_idx_q    <= '0;
            s1_frac_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_reg_q    <= REG_IN;
            s2_frac_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_oor_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_reg_q    <= s1_reg_d;
            s1_idx_q    <= s1_idx_d;
            s1_frac_q   <= s1_frac_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_reg_q    <= s2_reg_d;
            s2_frac_q   <= s2_frac_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_oor_q   <= out_oor_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_oor   = out_oor_q;

endmodule

// File: tb/tb_gelu_lut_interp.sv
// tb_gelu_lut_interp: directed checks of gelu_lut_interp with hand-computed expectations
module tb_gelu_lut_interp;

`ifdef GELU_INTERP_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_oor;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;

    int total = 0;
    int bad = 0;

    gelu_lut_interp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_oor   (out_oor),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input string tag, input logic [15:0] x, input logic [15:0] ed, input logic eo);
        int lat;
        in_valid = 1'b1;
        in_data = x;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_oor"}, out_oor, eo);
    endtask

    logic [15:0] bx [6] = '{16'h1000, 16'hFC00, 16'h2000, 16'hEC00, 16'h0F7F, 16'h0F80};
    logic [15:0] bd [6] = '{16'h1000, 16'hFF5D, 16'h2000, 16'h0000, 16'h0F7F, 16'h0F80};
    logic        bo [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int ni, no, first, last;
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_oor", out_oor, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        wr(6'd24, 16'hFF5D);
        wr(6'd25, 16'hFF4A);
        wr(6'd32, 16'h0000);
        wr(6'd33, 16'h0040);
        wr(6'd0,  16'h0123);
        wr(6'd1,  16'h0200);
        wr(6'd62, 16'h0F00);
        wr(6'd63, 16'h0F80);
        wr(6'd40, 16'h0100);
        wr(6'd41, 16'h0100);

        send("exact", 16'hFC00, 16'hFF5D, 1'b0);
        send("interp", 16'h0040, 16'h0020, 1'b0);
        send("negdiff", 16'hFC40, RND ? 16'hFF54 : 16'hFF53, 1'b0);
        wr(6'd33, 16'h0041);
        send("round", 16'h0001, RND ? 16'h0001 : 16'h0000, 1'b0);
        send("low", 16'hEC00, 16'h0000, 1'b1);
        send("min", 16'hF000, 16'h0123, 1'b0);
        send("top_in", 16'h0F7F, 16'h0F7F, 1'b0);
        send("high", 16'h0F80, 16'h0F80, 1'b1);
        send("max", 16'h7FFF, 16'h7FFF, 1'b1);
        send("most_neg", 16'h8000, 16'h0000, 1'b1);

        tick();
        ni = 0;
        no = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            in_valid = (ni < 6);
            in_data = (ni < 6) ? bx[ni] : 16'h0000;
            #1;
            if (c == 3 || c == 4) begin
                check("bp_ready", in_ready, 0);
                check("bp_valid", out_valid, 1);
                check("bp_hold", out_data, bd[0]);
            end
            if (out_valid && out_ready) begin
                if (no < 6) begin
                    check("bp_data", out_data, bd[no]);
                    check("bp_oor", out_oor, bo[no]);
                end
                if (first < 0) first = c;
                last = c;
                no++;
            end
            if (in_valid && in_ready) ni++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", no, 6);
        check("bp_gap", last - first, 5);

        tick();
        in_valid = 1'b1;
        in_data = 16'h0400;
        tick();
        cfg_we = 1'b1;
        cfg_addr = 6'd40;
        cfg_data = 16'h0200;
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b0;
        tick();
        check("col_valid", out_valid, 1);
        check("col_old", out_data, 16'h0100);
        tick();
        check("col_valid2", out_valid, 1);
        check("col_new", out_data, 16'h0200);

        tick();
        in_valid = 1'b1;
        in_data = 16'h1000;
        repeat (4) tick();
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_oor", out_oor, 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("rst_flush", out_valid, 0);
        end
        send("post_rst", 16'h0400, 16'h0200, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gelu_lut_interp.md
Name: gelu_lut_interp

Overview:
Streaming GELU activation unit for fixed-point signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS data. It replaces the fixed 64-entry nearest-sample LUT with four changes:
- parametrised LUT depth and step
- runtime-programmable table
- linear interpolation between adjacent samples
- valid/ready backpressure through a 3-stage pipeline

It sits between the FFN matmul output and the next layer's input FIFO.

Parameters:
DATA_WIDTH, 16, total bits of signed input/output/table entries
FRAC_BITS, 10, fractional bits (Q6.10 default)
ADDR_BITS, 6, LUT depth N = 2^ADDR_BITS entries
STEP_SHIFT, 7, sample step = 2^STEP_SHIFT LSBs (0.125 in Q6.10)
LUT_MIN, -4096, signed input value of entry 0 (-4.0 in Q6.10)

Ports:
clk        in   1           clock
rst_n      in   1           asynchronous, active-low reset
in_valid   in   1           input sample valid
in_ready   out  1           unit accepts input this cycle
in_data    in   DATA_WIDTH  signed input x
out_valid  out  1           output valid
out_ready  in   1           downstream accepts output
out_data   out  DATA_WIDTH  signed GELU(x)
out_oor    out  1           x was outside the table range
cfg_we     in   1           table write strobe
cfg_addr   in   ADDR_BITS   table write address
cfg_data   in   DATA_WIDTH  table write data

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_data=0, out_oor=0.
  - All internal stage valids=0.
  - Table contents are NOT reset: they are retained across reset and undefined until first written.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en (combinational).
  - Transfer occurs on in_valid & in_ready.
  - All stages advance only when en=1.
  - When en=0, every stage register and all outputs hold.
- Latency: 3 cycles from accepted input to out_valid, with no stall. Throughput is 1 sample/cycle.
- Stage 1 (range/address):
  - off = x - LUT_MIN, computed at DATA_WIDTH+1 signed.
  - If x < LUT_MIN: region LOW.
  - Else if off >= (N-1)<<STEP_SHIFT: region HIGH.
  - Else region IN, with idx = off>>STEP_SHIFT and frac = off[STEP_SHIFT-1:0].
- Stage 2: registered reads of lut[idx] and lut[idx+1]; x and region are carried along.
- Stage 3: compute and register out_data and out_oor:
  - IN: y = lut[idx] + ((lut[idx+1]-lut[idx]) * frac) >>> STEP_SHIFT.
    - The difference is DATA_WIDTH+1 signed.
    - The product is full width.
    - The shift is arithmetic (floor).
    - The sum saturates to the DATA_WIDTH signed range.
    - out_oor=0.
  - LOW: out_data=0, out_oor=1.
  - HIGH: out_data=x (passthrough), out_oor=1.
- Default in-range span: [-4.0, 3.875); x=0x0F80 is HIGH.
- Table writes: cfg_we is accepted every cycle, independent of en and stall.
  - A write becomes visible to stage-2 reads on the next cycle.
  - A same-cycle read of the written address returns the old value.
- Output stability: out_data and out_oor stay stable while out_valid=1 and out_ready=0.
- Ordering and loss: samples leave in order; none is dropped or duplicated.
- Reset mid-stream: in-flight samples are discarded. The first accepted sample after reset yields out_valid after 3 cycles.

Optional Feature:
Macro GELU_INTERP_ROUND_EN.
- Defined: the interpolation term is rounded to nearest, half toward +inf: (diff*frac + 2^(STEP_SHIFT-1)) >>> STEP_SHIFT.
- Undefined: truncation (floor), as above.
- Range handling, latency and interface are identical in both builds.

Decomposition:
- Package gelu_pkg holds:
  - Q-format constants: DATA_WIDTH, FRAC_BITS defaults, LUT_MIN, STEP_SHIFT
  - region encoding constants: REG_IN, REG_LOW, REG_HIGH
  - a signed saturate function
- Sub-module gelu_lut_ram:
  - N x DATA_WIDTH array
  - one synchronous write port
  - two synchronous read ports, addresses idx and idx+1 (idx+1 never exceeds N-1 when region IN)
  - read enable tied to en

Test Plan:
- Exact sample: program lut[24]=0xFF5D (-163), lut[25]=0xFF4A; x=0xFC00 (-1.0) -> out_data=0xFF5D, out_oor=0, out_valid 3 cycles after accept.
- Interpolation: lut[32]=0x0000, lut[33]=0x0040; x=0x0040 (off 4160, idx 32, frac 64) -> out_data=0x0020.
- Rounding: lut[32]=0, lut[33]=0x0041; x=0x0001 -> 0x0000 without the macro, 0x0001 with GELU_INTERP_ROUND_EN.
- Range boundaries:
  - x=0xEC00 (-5.0) -> 0x0000, oor=1.
  - x=0xF000 (-4.0) -> lut[0], oor=0.
  - x=0x0F7F -> idx 62, frac 127, oor=0.
  - x=0x0F80 -> 0x0F80, oor=1.
  - x=0x7FFF -> 0x7FFF, oor=1.
- Backpressure:
  - Stream 6 back-to-back inputs with out_ready=0 for 5 cycles.
  - Required: in_ready drops once 3 samples are held; out_data is constant while stalled.
  - After release: all 6 outputs appear in order with no gaps or duplicates.
- Write/reset interaction:
  - cfg write to lut[40] in the same cycle a sample reads it -> that sample gets the old value, the next sample the new one.
  - Assert rst_n low mid-stream -> out_valid=0 immediately; table contents survive.
